// File: rtl/vec_passthrough_checker.sv
// Self-checking harness: NUM_CH register-pipe lanes fed a per-lane, per-round pattern,
// compared after LATENCY cycles; counts mismatches (saturating) and records the first failing lane.
module vec_passthrough_checker #(
  parameter int NUM_CH  = 12,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int ROUNDS  = 4,
  parameter int SEED    = 1,
  parameter int ERR_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic             io_injectEn,
  input  logic [CH_W-1:0]  io_injectCh,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_pass,
  output logic [ERR_W-1:0] io_errCount,
  output logic             io_failValid,
  output logic [CH_W-1:0]  io_failCh
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = ERR_W + PW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     round;
  logic [2:0]        wait_cnt;
  logic [ERR_W-1:0]  err_count;
  logic              fail_valid;
  logic [CH_W-1:0]   fail_ch;

  logic [WIDTH-1:0]  stim     [NUM_CH];
  logic [WIDTH-1:0]  pipe_out [NUM_CH];

  logic [NUM_CH-1:0] mism;
  logic [CH_W-1:0]   low_ch;
  logic [PW-1:0]     pop;
  logic [SW-1:0]     sum;
  logic [ERR_W-1:0]  err_sat;
  logic [WIDTH-1:0]  obs;
  logic [WIDTH-1:0]  expv;

  function automatic logic [WIDTH-1:0] pattern(input int c, input logic [RW-1:0] r);
    return WIDTH'(SEED) + WIDTH'(c) + WIDTH'(r);
  endfunction

  // Lane pipes shift every cycle regardless of FSM state.
  generate
    if (LATENCY == 0) begin : g_comb
      for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign pipe_out[c] = stim[c];
      end
    end else begin : g_reg
      logic [WIDTH-1:0] stage [NUM_CH][LATENCY];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int c = 0; c < NUM_CH; c++)
            for (int s = 0; s < LATENCY; s++)
              stage[c][s] <= '0;
        end else begin
          for (int c = 0; c < NUM_CH; c++) begin
            stage[c][0] <= stim[c];
            for (int s = 1; s < LATENCY; s++)
              stage[c][s] <= stage[c][s-1];
          end
        end
      end
      for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign pipe_out[c] = stage[c][LATENCY-1];
      end
    end
  endgenerate

  // Descending scan so the last hit is the lowest mismatching lane.
  always_comb begin
    mism   = '0;
    low_ch = '0;
    obs    = '0;
    expv   = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      obs  = pipe_out[c];
      if (io_injectEn && (io_injectCh == CH_W'(c)))
        obs = obs ^ WIDTH'(1);
      expv = pattern(c, round);
      if (obs != expv) begin
        mism[c] = 1'b1;
        low_ch  = CH_W'(c);
      end
    end
    pop = '0;
    for (int c = 0; c < NUM_CH; c++)
      pop = pop + PW'(mism[c]);
    sum     = SW'(err_count) + SW'(pop);
    err_sat = (sum > SW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (io_start) state_nxt = S_DRIVE;
      S_DRIVE: state_nxt = (LATENCY > 0) ? S_WAIT : S_CHECK;
      S_WAIT:  if (wait_cnt == 3'd1) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (round == RW'(ROUNDS - 1)) ? S_DONE : S_DRIVE;
      S_DONE:  if (io_start) state_nxt = S_DRIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      round      <= '0;
      wait_cnt   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_ch    <= '0;
      for (int c = 0; c < NUM_CH; c++) stim[c] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (io_start) begin
            round      <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_ch    <= '0;
          end
        end
        S_DRIVE: begin
          for (int c = 0; c < NUM_CH; c++) stim[c] <= pattern(c, round);
          wait_cnt <= 3'(LATENCY);
        end
        S_WAIT: wait_cnt <= wait_cnt - 3'd1;
        S_CHECK: begin
          err_count <= err_sat;
          if (!fail_valid && (|mism)) begin
            fail_valid <= 1'b1;
            fail_ch    <= low_ch;
          end
          if (round != RW'(ROUNDS - 1)) round <= round + RW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_busy      = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
  assign io_done      = (state == S_DONE);
  assign io_pass      = io_done && (err_count == '0);
  assign io_errCount  = err_count;
  assign io_failValid = fail_valid;
  assign io_failCh    = fail_ch;

endmodule

// File: tb/tb_vec_passthrough_checker.sv
// Bench for vec_passthrough_checker: default instance plus an ERR_W=2, LATENCY=0 instance.
module tb_vec_passthrough_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        inj_en;
  logic [3:0]  inj_ch;
  logic        busy_a, done_a, pass_a, fv_a;
  logic [15:0] err_a;
  logic [3:0]  fch_a;
  logic        busy_b, done_b, pass_b, fv_b;
  logic [1:0]  err_b;
  logic [3:0]  fch_b;

  int checks = 0;
  int errors = 0;
  int sched_en [4];
  int sched_ch [4];
  bit sel_b = 1'b0;

  logic        m_busy, m_done, m_pass, m_fv;
  logic [15:0] m_err;
  logic [3:0]  m_fch;

  always #5 clock = ~clock;

  vec_passthrough_checker dut_a (
    .clock(clock), .reset(reset), .io_start(start_a),
    .io_injectEn(inj_en), .io_injectCh(inj_ch),
    .io_busy(busy_a), .io_done(done_a), .io_pass(pass_a),
    .io_errCount(err_a), .io_failValid(fv_a), .io_failCh(fch_a)
  );

  vec_passthrough_checker #(.ERR_W(2), .LATENCY(0)) dut_b (
    .clock(clock), .reset(reset), .io_start(start_b),
    .io_injectEn(inj_en), .io_injectCh(inj_ch),
    .io_busy(busy_b), .io_done(done_b), .io_pass(pass_b),
    .io_errCount(err_b), .io_failValid(fv_b), .io_failCh(fch_b)
  );

  always_comb begin
    m_busy = sel_b ? busy_b : busy_a;
    m_done = sel_b ? done_b : done_a;
    m_pass = sel_b ? pass_b : pass_a;
    m_fv   = sel_b ? fv_b   : fv_a;
    m_err  = sel_b ? {14'd0, err_b} : err_a;
    m_fch  = sel_b ? fch_b  : fch_a;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic chk_outputs(input string tag, input bit done_e, input bit pass_e,
                             input int err_e, input bit fv_e, input int fch_e);
    chk({tag, "_done"}, m_done, done_e);
    chk({tag, "_pass"}, m_pass, pass_e);
    chk({tag, "_err"},  m_err, err_e);
    chk({tag, "_fv"},   m_fv, fv_e);
    chk({tag, "_fch"},  m_fch, fch_e);
  endtask

  // Only injected lanes can mismatch: each in-range injected round adds exactly one error.
  task automatic run_and_check(input bit sel, input int lat, input int errmax, input string tag);
    int per, blen, err_e, fch_e;
    bit fv_e;
    sel_b = sel;
    per   = lat + 2;
    blen  = 4 * per;
    err_e = 0; fv_e = 0; fch_e = 0;
    for (int r = 0; r < 4; r++) begin
      if (sched_en[r] != 0 && sched_ch[r] < 12) begin
        if (!fv_e) begin fv_e = 1; fch_e = sched_ch[r]; end
        err_e = (err_e + 1 > errmax) ? errmax : err_e + 1;
      end
    end
    @(negedge clock);
    set_start(sel, 1'b1);
    for (int k = 0; k <= blen; k++) begin
      @(negedge clock);
      chk({tag, "_busy"}, m_busy, 32'(k < blen));
      chk({tag, "_donet"}, m_done, 32'(k == blen));
      if (k < blen) set_start(sel, 1'($urandom % 2));
      else          set_start(sel, 1'b0);
      if (k < blen && (k % per) == per - 1) begin
        inj_en = (sched_en[k / per] != 0);
        inj_ch = 4'(sched_ch[k / per]);
      end else begin
        inj_en = 1'($urandom % 2);
        inj_ch = 4'($urandom % 16);
      end
    end
    chk_outputs(tag, 1'b1, err_e == 0, err_e, fv_e, fch_e);
    inj_en = 1'b0;
    inj_ch = 4'd0;
  endtask

  task automatic set_sched(input int e0, input int e1, input int e2, input int e3, input int ch);
    sched_en[0] = e0; sched_en[1] = e1; sched_en[2] = e2; sched_en[3] = e3;
    for (int r = 0; r < 4; r++) sched_ch[r] = ch;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; inj_en = 1'b0; inj_ch = 4'd0;
    repeat (3) @(negedge clock);
    sel_b = 1'b0; chk("rst_a_busy", m_busy, 0); chk_outputs("rst_a", 0, 0, 0, 0, 0);
    sel_b = 1'b1; chk("rst_b_busy", m_busy, 0); chk_outputs("rst_b", 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clock);
    sel_b = 1'b0; chk("idle_a_busy", m_busy, 0); chk_outputs("idle_a", 0, 0, 0, 0, 0);

    // Clean run, whole-run injection, single-round injection, out-of-range lane.
    set_sched(0, 0, 0, 0, 0);   run_and_check(0, 2, 65535, "t1_clean");
    set_sched(1, 1, 1, 1, 5);   run_and_check(0, 2, 65535, "t2_lane5");
    set_sched(0, 0, 1, 0, 11);  run_and_check(0, 2, 65535, "t3_lane11_r2");
    set_sched(1, 1, 1, 1, 12);  run_and_check(0, 2, 65535, "t4_lane12");

    // Reset in cycle 7 of a run with one error already recorded.
    set_sched(1, 1, 1, 1, 3);
    sel_b = 1'b0;
    @(negedge clock); start_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      start_a = 1'b0;
      inj_en = 1'b1; inj_ch = 4'd3;
    end
    chk("t5_pre_err", m_err, 1);
    chk("t5_pre_busy", m_busy, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; inj_en = 1'b0;
    chk("t5_busy", m_busy, 0);
    chk_outputs("t5_rst", 0, 0, 0, 0, 0);
    set_sched(0, 0, 0, 0, 0);   run_and_check(0, 2, 65535, "t5_fresh");

    // Reset wins over a simultaneous start.
    @(negedge clock); reset = 1'b1; start_a = 1'b1;
    @(negedge clock); reset = 1'b0; start_a = 1'b0;
    chk("rst_win_busy", m_busy, 0);
    chk("rst_win_done", m_done, 0);

    // Narrow counter, combinational lanes: saturation, then restart from DONE.
    set_sched(1, 1, 1, 1, 0);   run_and_check(1, 0, 3, "t6_sat");
    set_sched(0, 0, 0, 0, 0);   run_and_check(1, 0, 3, "t6_restart");

    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < 4; r++) begin
        sched_en[r] = int'($urandom % 2);
        sched_ch[r] = int'($urandom_range(0, 15));
      end
      if (i % 2 == 0) run_and_check(0, 2, 65535, $sformatf("rnd_a%0d", i));
      else            run_and_check(1, 0, 3, $sformatf("rnd_b%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
